// File: rtl/wb_arbiter_scoreboard.sv
// Register-file write-port arbiter (ALU vs long unit) with a busy scoreboard for outstanding long results.
// 1-cycle registered write; ALU backpressured via pipe_hold on starvation; optional bypass: WB_SCOREBOARD_BYPASS_EN.
module wb_arbiter_scoreboard #(
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_src1,
  input  logic [4:0]  issue_src2,
  input  logic [4:0]  issue_dest,
  input  logic        issue_long,
  output logic        issue_stall,
`ifdef WB_SCOREBOARD_BYPASS_EN
  output logic        issue_fwd_src1,
  output logic        issue_fwd_src2,
`endif
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_dest,
  input  logic [31:0] alu_wb_val,
  input  logic        lu_wb_valid,
  input  logic [4:0]  lu_wb_dest,
  input  logic [31:0] lu_wb_val,
  output logic        lu_wb_ready,
  output logic        pipe_hold,
  output logic        rf_write_en,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_write_val
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic [31:0]   busy_q, busy_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          rf_en_q, rf_en_d;
  logic [4:0]    rf_dest_q, rf_dest_d;
  logic [31:0]   rf_val_q, rf_val_d;

  logic        starve_hit;
  logic        lu_grant;
  logic        pend_full;
  logic [31:0] busy_view;
  logic        accept;
  logic        sb_set;
  logic        sb_clr;

  // Combinational outputs are forced low while reset is asserted.
  assign starve_hit  = (wait_q == WW'(STARVE_LIMIT));
  assign lu_grant    = rst & lu_wb_valid & (~alu_wb_valid | starve_hit);
  assign lu_wb_ready = lu_grant;
  assign pipe_hold   = rst & alu_wb_valid & lu_wb_valid & starve_hit;

`ifdef WB_SCOREBOARD_BYPASS_EN
  // A register being written back this cycle is readable from lu_wb_val.
  always_comb begin
    busy_view = busy_q;
    if (lu_grant) begin
      busy_view[lu_wb_dest] = 1'b0;
    end
  end

  assign issue_fwd_src1 = issue_valid & lu_grant & (issue_src1 != 5'd0) & (lu_wb_dest == issue_src1);
  assign issue_fwd_src2 = issue_valid & lu_grant & (issue_src2 != 5'd0) & (lu_wb_dest == issue_src2);
`else
  assign busy_view = busy_q;
`endif

  assign pend_full   = (pending_q == PW'(MAX_PENDING));
  assign issue_stall = rst & issue_valid &
                       (busy_view[issue_src1] | busy_view[issue_src2] | busy_view[issue_dest] |
                        (issue_long & pend_full) | pipe_hold);

  assign accept = issue_valid & issue_long & ~issue_stall;
  assign sb_set = accept & (issue_dest != 5'd0);
  // Writeback to a register that is not busy is a protocol error and leaves the scoreboard alone.
  assign sb_clr = lu_grant & busy_q[lu_wb_dest];

  always_comb begin
    busy_d = busy_q;
    if (sb_clr) begin
      busy_d[lu_wb_dest] = 1'b0;
    end
    if (sb_set) begin
      busy_d[issue_dest] = 1'b1;
    end
    busy_d[0] = 1'b0;

    pending_d = pending_q;
    case ({sb_set, sb_clr})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_comb begin
    wait_d = '0;
    if (lu_wb_valid && !lu_grant) begin
      wait_d = starve_hit ? wait_q : wait_q + WW'(1);
    end
  end

  always_comb begin
    rf_en_d   = 1'b0;
    rf_dest_d = rf_dest_q;
    rf_val_d  = rf_val_q;
    if (lu_grant) begin
      rf_en_d   = (lu_wb_dest != 5'd0);
      rf_dest_d = lu_wb_dest;
      rf_val_d  = lu_wb_val;
    end else if (alu_wb_valid) begin
      rf_en_d   = (alu_wb_dest != 5'd0);
      rf_dest_d = alu_wb_dest;
      rf_val_d  = alu_wb_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= '0;
      pending_q <= '0;
      wait_q    <= '0;
      rf_en_q   <= 1'b0;
      rf_dest_q <= '0;
      rf_val_q  <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
      rf_en_q   <= rf_en_d;
      rf_dest_q <= rf_dest_d;
      rf_val_q  <= rf_val_d;
    end
  end

  assign rf_write_en  = rf_en_q;
  assign rf_dest      = rf_dest_q;
  assign rf_write_val = rf_val_q;

endmodule

// File: tb/tb_wb_arbiter_scoreboard.sv
// Bench for wb_arbiter_scoreboard: arbitration vector table plus hand sequences for hazards, limits and reset.
module tb_wb_arbiter_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        issue_valid, issue_long, issue_stall;
  logic [4:0]  issue_src1, issue_src2, issue_dest;
  logic        alu_wb_valid, lu_wb_valid, lu_wb_ready, pipe_hold;
  logic [4:0]  alu_wb_dest, lu_wb_dest;
  logic [31:0] alu_wb_val, lu_wb_val;
  logic        rf_write_en;
  logic [4:0]  rf_dest;
  logic [31:0] rf_write_val;
`ifdef WB_SCOREBOARD_BYPASS_EN
  logic        issue_fwd_src1, issue_fwd_src2;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_arbiter_scoreboard #(.MAX_PENDING(4), .STARVE_LIMIT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_src1   (issue_src1),
    .issue_src2   (issue_src2),
    .issue_dest   (issue_dest),
    .issue_long   (issue_long),
    .issue_stall  (issue_stall),
`ifdef WB_SCOREBOARD_BYPASS_EN
    .issue_fwd_src1 (issue_fwd_src1),
    .issue_fwd_src2 (issue_fwd_src2),
`endif
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_dest  (alu_wb_dest),
    .alu_wb_val   (alu_wb_val),
    .lu_wb_valid  (lu_wb_valid),
    .lu_wb_dest   (lu_wb_dest),
    .lu_wb_val    (lu_wb_val),
    .lu_wb_ready  (lu_wb_ready),
    .pipe_hold    (pipe_hold),
    .rf_write_en  (rf_write_en),
    .rf_dest      (rf_dest),
    .rf_write_val (rf_write_val)
  );

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_d;
    logic [31:0] alu_val;
    logic        lu_v;
    logic [4:0]  lu_d;
    logic [31:0] lu_val;
    logic        exp_rdy;
    logic        exp_hold;
    logic        exp_en;
    logic [4:0]  exp_dest;
    logic [31:0] exp_val;
    logic        chk_dv;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  dest;
    logic [31:0] val;
    logic        chk_dv;
  } wr_t;

  wr_t  exp_q[$];
  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic en, input logic [4:0] d, input logic [31:0] v, input logic dv);
    wr_t w;
    w.en = en; w.dest = d; w.val = v; w.chk_dv = dv;
    exp_q.push_back(w);
  endtask

  // Advance one edge, then compare the registered write port against the oldest expectation.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("rf_write_en", rf_write_en, w.en);
      if (w.chk_dv) begin
        chk("rf_dest", rf_dest, w.dest);
        chk("rf_write_val", rf_write_val, w.val);
      end
    end
  endtask

  task automatic drive_wb(input logic av, input logic [4:0] ad, input logic [31:0] aval,
                          input logic lv, input logic [4:0] ld, input logic [31:0] lval);
    alu_wb_valid = av; alu_wb_dest = ad; alu_wb_val = aval;
    lu_wb_valid  = lv; lu_wb_dest  = ld; lu_wb_val  = lval;
  endtask

  task automatic drive_issue(input logic v, input logic lng, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [4:0] d);
    issue_valid = v; issue_long = lng; issue_src1 = s1; issue_src2 = s2; issue_dest = d;
  endtask

  initial begin
    //        alu_v d   val           lu_v d   val           rdy  hold en   dest val           dv
    tbl[0] = '{1'b1, 5, 32'h0000_1234, 1'b0, 0, 32'h0,        1'b0,1'b0,1'b1, 5, 32'h0000_1234, 1'b1};
    tbl[1] = '{1'b0, 0, 32'h0,         1'b0, 0, 32'h0,        1'b0,1'b0,1'b0, 5, 32'h0000_1234, 1'b1};
    tbl[2] = '{1'b0, 0, 32'h0,         1'b1, 9, 32'h0000_AAAA,1'b1,1'b0,1'b1, 9, 32'h0000_AAAA, 1'b1};
    tbl[3] = '{1'b1, 3, 32'h0000_0033, 1'b1, 4, 32'h0000_0044,1'b0,1'b0,1'b1, 3, 32'h0000_0033, 1'b1};
    tbl[4] = '{1'b0, 0, 32'h0,         1'b0, 0, 32'h0,        1'b0,1'b0,1'b0, 3, 32'h0000_0033, 1'b1};
    tbl[5] = '{1'b1, 0, 32'h0000_0077, 1'b0, 0, 32'h0,        1'b0,1'b0,1'b0, 0, 32'h0,         1'b0};
    tbl[6] = '{1'b0, 0, 32'h0,         1'b1, 0, 32'h0000_0088,1'b1,1'b0,1'b0, 0, 32'h0,         1'b0};
    tbl[7] = '{1'b1, 6, 32'h0000_0066, 1'b0, 0, 32'h0,        1'b0,1'b0,1'b1, 6, 32'h0000_0066, 1'b1};

    // Reset held with every request active.
    rst = 1'b0;
    drive_issue(1, 1, 5'd1, 5'd2, 5'd3);
    drive_wb(1, 5'd5, 32'h1234, 1, 5'd6, 32'h5678);
    repeat (2) @(posedge clk);
    #1;
    chk("reset rf_write_en", rf_write_en, 1'b0);
    chk("reset rf_dest", rf_dest, 5'd0);
    chk("reset rf_write_val", rf_write_val, 32'h0);
    chk("reset issue_stall", issue_stall, 1'b0);
    chk("reset lu_wb_ready", lu_wb_ready, 1'b0);
    chk("reset pipe_hold", pipe_hold, 1'b0);
    drive_issue(0, 0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;

    // Arbitration and write-port vectors; the first one is the first write after reset.
    for (int i = 0; i < 8; i++) begin
      drive_wb(tbl[i].alu_v, tbl[i].alu_d, tbl[i].alu_val, tbl[i].lu_v, tbl[i].lu_d, tbl[i].lu_val);
      #2;
      chk($sformatf("tbl%0d lu_wb_ready", i), lu_wb_ready, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d pipe_hold", i), pipe_hold, tbl[i].exp_hold);
      push(tbl[i].exp_en, tbl[i].exp_dest, tbl[i].exp_val, tbl[i].chk_dv);
      tick();
    end

    // Starvation: ALU wins three cycles, long unit forced through on the fourth.
    for (int c = 0; c < 4; c++) begin
      drive_wb(1, 5'd10, 32'h100 + c, 1, 5'd11, 32'hBEEF);
      #2;
      chk($sformatf("starve c%0d lu_wb_ready", c), lu_wb_ready, (c == 3));
      chk($sformatf("starve c%0d pipe_hold", c), pipe_hold, (c == 3));
      if (c == 3) push(1, 5'd11, 32'hBEEF, 1);
      else        push(1, 5'd10, 32'h100 + c, 1);
      tick();
    end
    drive_wb(1, 5'd10, 32'h103, 1, 5'd12, 32'hC0DE);
    #2;
    chk("starve counter cleared lu_wb_ready", lu_wb_ready, 1'b0);
    chk("starve counter cleared pipe_hold", pipe_hold, 1'b0);
    push(1, 5'd10, 32'h103, 1);
    tick();
    drive_wb(0, 0, 0, 0, 0, 0);
    tick();

    // Long issue to r7, then a dependent instruction waits for the grant.
    drive_issue(1, 1, 5'd0, 5'd0, 5'd7);
    #2;
    chk("long issue r7 stall", issue_stall, 1'b0);
    tick();
    drive_issue(1, 0, 5'd7, 5'd0, 5'd8);
    for (int c = 0; c < 2; c++) begin
      #2;
      chk($sformatf("raw r7 stall c%0d", c), issue_stall, 1'b1);
      tick();
    end
    drive_wb(0, 0, 0, 1, 5'd7, 32'h777);
    #2;
    chk("raw r7 grant lu_wb_ready", lu_wb_ready, 1'b1);
    chk("raw r7 stall in grant cycle", issue_stall, BYP ? 1'b0 : 1'b1);
`ifdef WB_SCOREBOARD_BYPASS_EN
    chk("raw r7 issue_fwd_src1", issue_fwd_src1, 1'b1);
`endif
    push(1, 5'd7, 32'h777, 1);
    tick();
    drive_wb(0, 0, 0, 0, 0, 0);
    #2;
    chk("raw r7 stall after grant", issue_stall, 1'b0);
    tick();

    // Zero-destination long issue must not count; then fill the pending limit.
    drive_issue(1, 1, 5'd0, 5'd0, 5'd0);
    #2;
    chk("long issue r0 stall", issue_stall, 1'b0);
    tick();
    for (int d = 1; d <= 4; d++) begin
      drive_issue(1, 1, 5'd0, 5'd0, 5'(d));
      #2;
      chk($sformatf("pending fill r%0d stall", d), issue_stall, 1'b0);
      tick();
    end
    drive_issue(1, 1, 5'd0, 5'd0, 5'd5);
    #2;
    chk("pending full stall", issue_stall, 1'b1);
    tick();
    drive_wb(0, 0, 0, 1, 5'd1, 32'h11);
    #2;
    chk("pending full stall in grant cycle", issue_stall, 1'b1);
    push(1, 5'd1, 32'h11, 1);
    tick();
    drive_wb(0, 0, 0, 0, 0, 0);
    #2;
    chk("pending stall cleared", issue_stall, 1'b0);
    tick();
    drive_issue(0, 0, 5'd0, 5'd0, 5'd0);
    for (int d = 2; d <= 5; d++) begin
      drive_wb(0, 0, 0, 1, 5'(d), 32'h11 * d);
      push(1, 5'(d), 32'h11 * d, 1);
      tick();
    end
    drive_wb(0, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges wipes a busy register.
    drive_issue(1, 1, 5'd0, 5'd0, 5'd3);
    #2;
    chk("long issue r3 stall", issue_stall, 1'b0);
    tick();
    drive_issue(1, 0, 5'd3, 5'd0, 5'd9);
    #2;
    chk("raw r3 stall before reset", issue_stall, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("midreset rf_write_en", rf_write_en, 1'b0);
    chk("midreset rf_dest", rf_dest, 5'd0);
    chk("midreset rf_write_val", rf_write_val, 32'h0);
    chk("midreset issue_stall", issue_stall, 1'b0);
    rst = 1'b1;
    #1;
    chk("r3 after reset release stall", issue_stall, 1'b0);
    tick();
    chk("r3 after reset next edge stall", issue_stall, 1'b0);
    drive_issue(0, 0, 5'd0, 5'd0, 5'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_scoreboard.md
Name: wb_arbiter_scoreboard

Overview:
- Shares the single register-file write port between the in-order ALU writeback stage and a long-latency multiply/divide unit.
- Keeps a per-register busy scoreboard for outstanding long-unit results.
- Stalls issue on RAW/WAW hazards against those results.
- Sits between the decode/issue stage, the writeback stage and the register file write inputs (enable, destination, value).

Parameters:
- MAX_PENDING, 4, maximum outstanding long-unit results (1..31).
- STARVE_LIMIT, 3, consecutive cycles a long-unit request may lose arbitration before it is forced through (>=1).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- issue_valid  input  1  instruction in issue stage.
- issue_src1  input  5  first source register.
- issue_src2  input  5  second source register.
- issue_dest  input  5  destination register.
- issue_long  input  1  instruction goes to long unit.
- issue_stall  output  1  hold issue stage this cycle.
- alu_wb_valid  input  1  ALU writeback request.
- alu_wb_dest  input  5  ALU writeback register.
- alu_wb_val  input  32  ALU writeback value.
- lu_wb_valid  input  1  long-unit writeback request.
- lu_wb_dest  input  5  long-unit writeback register.
- lu_wb_val  input  32  long-unit writeback value.
- lu_wb_ready  output  1  long-unit request granted this cycle.
- pipe_hold  output  1  freeze writeback stage; ALU request must be re-presented unchanged next cycle.
- rf_write_en  output  1  register-file write enable (registered).
- rf_dest  output  5  register-file destination (registered).
- rf_write_val  output  32  register-file write data (registered).

Behaviour:
- Reset (rst low, asynchronous): rf_write_en=0, rf_dest=0, rf_write_val=0, busy[31:0]=0, pending=0, wait_cnt=0.
- During reset, issue_stall, lu_wb_ready and pipe_hold are 0.
- Reset mid-operation discards all pending scoreboard state.

Arbitration (combinational grant):
- Long unit is granted (lu_wb_ready=1) when lu_wb_valid and either (!alu_wb_valid) or (wait_cnt==STARVE_LIMIT).
- pipe_hold=1 exactly when both request and the long unit is granted through starvation.
- Otherwise the ALU wins, lu_wb_ready=0, and the long unit must hold its request stable.

Starvation counter:
- wait_cnt increments when lu_wb_valid and not granted.
- It clears on grant or when lu_wb_valid=0.
- It saturates at STARVE_LIMIT.

Write port (1-cycle latency):
- On each edge, the granted request is registered into rf_write_en/rf_dest/rf_write_val.
- If neither side requests, rf_write_en=0 and rf_dest/rf_write_val hold.
- A request with dest 0 registers rf_write_en=0.

Scoreboard:
- A long issue is accepted when issue_valid & issue_long & !issue_stall.
- On acceptance with issue_dest!=0, busy[issue_dest] is set and pending increments.
- Granted long writeback clears busy[lu_wb_dest] and decrements pending.
- Simultaneous accept and grant leaves pending unchanged.
- busy[0] is never set.

Stall:
- issue_stall = issue_valid & (busy[src1] | busy[src2] | busy[dest] | (issue_long & pending==MAX_PENDING) | pipe_hold).
- Hazard checks use registered busy bits, so a register whose grant occurs this cycle still stalls (base build).
- Long-unit writeback to a non-busy register is a protocol error: write proceeds, busy and pending are untouched.

Optional Feature:
- Macro: WB_SCOREBOARD_BYPASS_EN.
- Defined: a source or destination matching lu_wb_dest while lu_wb_ready=1 is treated as not busy that cycle, removing one stall cycle.
- Defined: adds outputs issue_fwd_src1/issue_fwd_src2 (1 bit) flagging that the operand must be taken from lu_wb_val.
- Undefined: no bypass and no fwd ports; the stall lasts until the cycle after the grant.

Test Plan:
- Reset: hold rst low with requests active -> all outputs 0; release -> first ALU write (dest 5, 0x1234) appears on rf_* after one edge.
- Long issue, then dependency: long issue dest 7 -> next cycle issue with src1=7 gives issue_stall=1 until the cycle after lu_wb grant for dest 7 (bypass build: stall drops in the grant cycle, issue_fwd_src1=1).
- Contention and starvation: ALU and long unit both valid continuously, STARVE_LIMIT=3 -> ALU granted 3 cycles, 4th cycle lu_wb_ready=1 and pipe_hold=1, wait_cnt returns 0.
- Pending limit: issue 4 long ops to dests 1-4 -> 5th long issue stalls; one grant -> stall clears the following cycle.
- Zero register: ALU write to dest 0 -> rf_write_en=0; long issue dest 0 -> busy unchanged, pending unchanged.
- Async reset mid-operation: rst asserted between edges with busy[3]=1 -> busy cleared immediately; src1=3 no longer stalls after release.
